// File: rtl/pc_pkg.sv
// Shared types and constants for the next-PC unit.
//   pcu_state_t : run-control state (IDLE / RUN / DONE)
//   pc_sel_t    : next-PC source select
//   PC_W        : program counter width
package pc_pkg;

   localparam int unsigned PC_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } pcu_state_t;

   typedef enum logic [2:0] {
      SEL_START,
      SEL_HOLD,
      SEL_RAS,
      SEL_TARGET,
      SEL_BRANCH,
      SEL_SEQ
   } pc_sel_t;

endpackage

// File: rtl/pc_next_unit_if.sv
// Decode/PC-register side bundle of the next-PC unit.
//   master : decoder / PC register side (drives controls and pc_in, sees results)
//   slave  : pc_next_unit side
interface pc_next_unit_if #(
   parameter int unsigned RS_DEPTH = 4
);
   import pc_pkg::*;

   logic [PC_W-1:0]           pc_in;
   logic                      start;
   logic                      stall;
   logic                      halt;
   logic                      branch_taken;
   logic [7:0]                branch_off;
   logic                      jump;
   logic [PC_W-1:0]           jump_target;
   logic                      call;
   logic                      ret;
   logic [PC_W-1:0]           pcnext_out;
   logic                      done;
   logic [$clog2(RS_DEPTH):0] rs_count;
   logic                      rs_overflow;
   logic                      rs_underflow;

   modport master (
      output pc_in, start, stall, halt, branch_taken, branch_off, jump, jump_target, call, ret,
      input  pcnext_out, done, rs_count, rs_overflow, rs_underflow
   );

   modport slave (
      input  pc_in, start, stall, halt, branch_taken, branch_off, jump, jump_target, call, ret,
      output pcnext_out, done, rs_count, rs_overflow, rs_underflow
   );

endinterface

// File: rtl/return_stack.sv
// Hardware return-address LIFO.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/data_i : push data_i (ignored when full or when pop/clear is active)
//   pop_i         : discard top entry (ignored when empty)
//   clear_i       : empty the stack (wins over push/pop)
//   top_o         : current top entry (undefined content when empty)
//   count_o       : occupancy, 0..DEPTH
//   full_o/empty_o: occupancy flags
module return_stack #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 16,
   localparam int unsigned CW = $clog2(DEPTH) + 1,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] top_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    count_m1;
   logic             do_push;

   assign full_o   = (count_q == CW'(DEPTH));
   assign empty_o  = (count_q == '0);
   assign count_o  = count_q;
   assign count_m1 = count_q - CW'(1);
   assign top_o    = mem_q[count_m1[AW-1:0]];
   assign do_push  = push_i && !pop_i && !clear_i && !full_o;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (pop_i && !empty_o) begin
         count_d = count_m1;
      end else if (do_push) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Storage is indexed by occupancy: the next free slot is mem_q[count_q].
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_push) begin
         mem_q[count_q[AW-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC generator with run-control FSM and return-address stack.
//   CLK          : system clock, rising edge
//   reset_ctrl_n : async active-low reset
//   pcu_io       : slave side of pc_next_unit_if (controls, pc_in, pcnext_out, status)
// pcnext_out is purely combinational; the external PC register is the only pipeline stage.
module pc_next_unit
   import pc_pkg::*;
#(
   parameter logic [PC_W-1:0] START_ADDR = 16'h0000,
   parameter int unsigned     RS_DEPTH   = 4
) (
   input logic                  CLK,
   input logic                  reset_ctrl_n,
   pc_next_unit_if.slave        pcu_io
);

   localparam int unsigned CW = $clog2(RS_DEPTH) + 1;

   pcu_state_t      state_q, state_d;
   pc_sel_t         sel;
   logic            rs_push, rs_pop, rs_clear;
   logic            set_ovf, set_unf;
   logic            ovf_q, ovf_d, unf_q, unf_d;
   logic [PC_W-1:0] rs_top;
   logic [CW-1:0]   rs_cnt;
   logic            rs_full, rs_empty;
   logic [PC_W-1:0] pc_seq;

   assign pc_seq = pcu_io.pc_in + PC_W'(1);

   return_stack #(
      .DEPTH (RS_DEPTH),
      .WIDTH (PC_W)
   ) u_ras (
      .clk_i   (CLK),
      .rst_ni  (reset_ctrl_n),
      .push_i  (rs_push),
      .pop_i   (rs_pop),
      .clear_i (rs_clear),
      .data_i  (pc_seq),
      .top_o   (rs_top),
      .count_o (rs_cnt),
      .full_o  (rs_full),
      .empty_o (rs_empty)
   );

   // State register
   always_ff @(posedge CLK or negedge reset_ctrl_n) begin
      if (!reset_ctrl_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start overrides everything in every state
   always_comb begin
      state_d = state_q;
      if (pcu_io.start) begin
         state_d = RUN;
      end else if (state_q == RUN && !pcu_io.stall && pcu_io.halt) begin
         state_d = DONE;
      end
   end

   // Output decode: next-PC source, stack operations and flag updates
   always_comb begin
      sel      = SEL_SEQ;
      rs_push  = 1'b0;
      rs_pop   = 1'b0;
      rs_clear = 1'b0;
      set_ovf  = 1'b0;
      set_unf  = 1'b0;
      if (pcu_io.start) begin
         sel      = SEL_START;
         rs_clear = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: sel = SEL_START;
            RUN: begin
               if (pcu_io.stall || pcu_io.halt) begin
                  sel = SEL_HOLD;
               end else if (pcu_io.ret) begin
                  // ret beats call; an empty-stack return falls through sequentially
                  if (!rs_empty) begin
                     sel    = SEL_RAS;
                     rs_pop = 1'b1;
                  end else begin
                     sel     = SEL_SEQ;
                     set_unf = 1'b1;
                  end
               end else if (pcu_io.call) begin
                  sel     = SEL_TARGET;
                  rs_push = !rs_full;
                  set_ovf = rs_full;
               end else if (pcu_io.jump) begin
                  sel = SEL_TARGET;
               end else if (pcu_io.branch_taken) begin
                  sel = SEL_BRANCH;
               end
            end
            DONE:    sel = SEL_HOLD;
            default: sel = SEL_START;
         endcase
      end
   end

   always_comb begin
      unique case (sel)
         SEL_START:  pcu_io.pcnext_out = START_ADDR;
         SEL_HOLD:   pcu_io.pcnext_out = pcu_io.pc_in;
         SEL_RAS:    pcu_io.pcnext_out = rs_top;
         SEL_TARGET: pcu_io.pcnext_out = pcu_io.jump_target;
         SEL_BRANCH: pcu_io.pcnext_out = pcu_io.pc_in
                                         + {{(PC_W-8){pcu_io.branch_off[7]}}, pcu_io.branch_off};
         default:    pcu_io.pcnext_out = pc_seq;
      endcase
   end

   // Sticky error flags, cleared only by reset or start
   assign ovf_d = pcu_io.start ? 1'b0 : (ovf_q | set_ovf);
   assign unf_d = pcu_io.start ? 1'b0 : (unf_q | set_unf);

   always_ff @(posedge CLK or negedge reset_ctrl_n) begin
      if (!reset_ctrl_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign pcu_io.done         = (state_q == DONE);
   assign pcu_io.rs_count     = rs_cnt;
   assign pcu_io.rs_overflow  = ovf_q;
   assign pcu_io.rs_underflow = unf_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: a behavioural model pushes expected outputs into a
// queue as each cycle's stimulus is driven; they are popped and compared on the falling edge.
module tb_pc_next_unit;

   localparam int unsigned RsDepth   = 4;
   localparam logic [15:0] StartAddr = 16'h0000;
   localparam int          MIdle = 0, MRun = 1, MDone = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pc_next_unit_if #(.RS_DEPTH(RsDepth)) bus ();

   pc_next_unit #(
      .START_ADDR (StartAddr),
      .RS_DEPTH   (RsDepth)
   ) dut (
      .CLK          (clk),
      .reset_ctrl_n (rst_n),
      .pcu_io       (bus)
   );

   // PC register fed by the DUT
   logic [15:0] pc_reg;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_reg <= StartAddr;
      else        pc_reg <= bus.pcnext_out;
   end

   typedef struct packed {
      logic [15:0] pc;
      logic        done;
      logic [2:0]  cnt;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state
   int          m_state;
   logic [15:0] m_stack[$];
   logic        m_ovf, m_unf;

   logic        fb;
   logic [15:0] pc_drv;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic compare(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         check_eq({tag, ".queue_empty"}, 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      check_eq({tag, ".pc"},   32'(bus.pcnext_out),   32'(e.pc));
      check_eq({tag, ".done"}, 32'(bus.done),         32'(e.done));
      check_eq({tag, ".cnt"},  32'(bus.rs_count),     32'(e.cnt));
      check_eq({tag, ".ovf"},  32'(bus.rs_overflow),  32'(e.ovf));
      check_eq({tag, ".unf"},  32'(bus.rs_underflow), 32'(e.unf));
   endtask

   task automatic model_reset();
      m_state = MIdle;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic clear_ctl();
      fb               = 1'b0;
      pc_drv           = 16'h0000;
      bus.start        = 1'b0;
      bus.stall        = 1'b0;
      bus.halt         = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_off   = 8'h00;
      bus.jump         = 1'b0;
      bus.jump_target  = 16'h0000;
      bus.call         = 1'b0;
      bus.ret          = 1'b0;
   endtask

   // Drive one cycle (controls already set), predict, compare at negedge, then advance the model.
   // With mid_reset set, async reset is pulsed inside the cycle instead of a normal compare.
   task automatic cycle(input string tag, input bit mid_reset = 1'b0);
      logic [15:0] p, e;
      int          ns;
      logic        nov, nun;
      logic [15:0] nstk[$];
      bus.pc_in = fb ? pc_reg : pc_drv;
      p    = bus.pc_in;
      ns   = m_state;
      nov  = m_ovf;
      nun  = m_unf;
      nstk = m_stack;
      e    = StartAddr;
      if (bus.start) begin
         e = StartAddr; ns = MRun; nstk.delete(); nov = 1'b0; nun = 1'b0;
      end else if (m_state == MIdle) begin
         e = StartAddr;
      end else if (m_state == MDone) begin
         e = p;
      end else if (bus.stall) begin
         e = p;
      end else if (bus.halt) begin
         e = p; ns = MDone;
      end else if (bus.ret) begin
         if (nstk.size() > 0) e = nstk.pop_back();
         else begin e = p + 16'd1; nun = 1'b1; end
      end else if (bus.call) begin
         e = bus.jump_target;
         if (nstk.size() == RsDepth) nov = 1'b1;
         else nstk.push_back(p + 16'd1);
      end else if (bus.jump) begin
         e = bus.jump_target;
      end else if (bus.branch_taken) begin
         e = p + {{8{bus.branch_off[7]}}, bus.branch_off};
      end else begin
         e = p + 16'd1;
      end
      if (mid_reset) begin
         #2 rst_n = 1'b0;
         #1;
         exp_q.push_back('{pc: StartAddr, done: 1'b0, cnt: 3'd0, ovf: 1'b0, unf: 1'b0});
         compare(tag);
         @(posedge clk);
         #1 rst_n = 1'b1;
         model_reset();
         return;
      end
      exp_q.push_back('{pc: e, done: (m_state == MDone), cnt: 3'(m_stack.size()),
                        ovf: m_ovf, unf: m_unf});
      @(negedge clk);
      compare(tag);
      @(posedge clk);
      m_state = ns;
      m_stack = nstk;
      m_ovf   = nov;
      m_unf   = nun;
      #1;
   endtask

   initial begin
      clear_ctl();
      model_reset();
      bus.pc_in = 16'h0000;
      rst_n = 1'b0;
      #2;
      exp_q.push_back('{pc: StartAddr, done: 1'b0, cnt: 3'd0, ovf: 1'b0, unf: 1'b0});
      compare("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Idle ignores everything but start
      pc_drv = 16'h0055; bus.branch_taken = 1'b1; bus.jump = 1'b1; bus.jump_target = 16'h0abc;
      cycle("idle_ignore");
      clear_ctl();

      // Start then free-run with feedback
      fb = 1'b1; bus.start = 1'b1;
      cycle("start");
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) cycle($sformatf("seq%0d", i));
      clear_ctl();

      // Branch arithmetic and wrap
      pc_drv = 16'h0010; bus.branch_taken = 1'b1; bus.branch_off = 8'hf8;
      cycle("branch_back");
      pc_drv = 16'h0002; bus.branch_off = 8'hfc;
      cycle("branch_wrap");
      pc_drv = 16'h0030; bus.branch_off = 8'h7f;
      cycle("branch_fwd");
      clear_ctl();
      pc_drv = 16'hffff;
      cycle("seq_wrap");

      // Call / return
      pc_drv = 16'h0020; bus.call = 1'b1; bus.jump_target = 16'h0100;
      cycle("call");
      clear_ctl();
      pc_drv = 16'h0105; bus.ret = 1'b1;
      cycle("ret");
      clear_ctl();
      pc_drv = 16'h0022;
      cycle("after_ret");

      // Overflow then underflow
      for (int i = 0; i < 5; i++) begin
         clear_ctl();
         pc_drv = 16'h0200 + 16'(i); bus.call = 1'b1; bus.jump_target = 16'h0300 + 16'(i);
         cycle($sformatf("nest_call%0d", i));
      end
      for (int i = 0; i < 5; i++) begin
         clear_ctl();
         pc_drv = 16'h0400 + 16'(i); bus.ret = 1'b1;
         cycle($sformatf("nest_ret%0d", i));
      end
      clear_ctl();
      pc_drv = 16'h0500;
      cycle("flags_sticky");

      // Simultaneous call and ret: ret wins
      pc_drv = 16'h0600; bus.call = 1'b1; bus.jump_target = 16'h0700;
      cycle("call_pre");
      bus.ret = 1'b1; pc_drv = 16'h0710; bus.jump_target = 16'h0800;
      cycle("call_and_ret");
      clear_ctl();
      pc_drv = 16'h0720;
      cycle("after_call_ret");

      // Stall over jump, stalled call has no stack effect
      for (int i = 0; i < 3; i++) begin
         clear_ctl();
         pc_drv = 16'h0077; bus.stall = 1'b1; bus.jump = 1'b1; bus.call = (i == 1);
         bus.jump_target = 16'h1234;
         cycle($sformatf("stall%0d", i));
      end
      bus.stall = 1'b0; bus.call = 1'b0;
      cycle("jump");
      clear_ctl();

      // Stall beats halt
      pc_drv = 16'h0030; bus.stall = 1'b1; bus.halt = 1'b1;
      cycle("stall_halt");
      clear_ctl();

      // Restart clears flags
      pc_drv = 16'h0050; bus.start = 1'b1; bus.jump = 1'b1; bus.jump_target = 16'h0999;
      cycle("restart");
      clear_ctl();
      pc_drv = 16'h0001;
      cycle("restart_clr");

      // Halt / done / restart from done
      pc_drv = 16'h0042; bus.halt = 1'b1;
      cycle("halt");
      clear_ctl();
      pc_drv = 16'h0042; bus.jump = 1'b1; bus.jump_target = 16'h0555;
      cycle("done_hold");
      clear_ctl();
      pc_drv = 16'h0099; bus.call = 1'b1; bus.jump_target = 16'h0555;
      cycle("done_ignore");
      clear_ctl();
      pc_drv = 16'h0042; bus.start = 1'b1;
      cycle("done_start");
      clear_ctl();
      pc_drv = 16'h0010;
      cycle("done_cleared");

      // Async reset mid-run with a stack entry present
      pc_drv = 16'h0500; bus.call = 1'b1; bus.jump_target = 16'h0900;
      cycle("pre_reset_call");
      clear_ctl();
      pc_drv = 16'h0901;
      cycle("async_reset", 1'b1);
      pc_drv = 16'h0123; bus.branch_taken = 1'b1; bus.branch_off = 8'h05;
      cycle("post_reset_idle");
      clear_ctl();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Generates the next-PC value each cycle and drives the program counter register's next-PC input.
- Consumes the current PC, fed back from the PC register, plus control decode (branch/jump/call/return/halt/stall).
- Holds a small hardware return-address stack and a run-control state machine (idle/run/done).
- Output is combinational from the current state and inputs; the PC register supplies the single register stage.

Parameters:
START_ADDR, 16'h0000, PC value presented while idle and on (re)start.
RS_DEPTH, 4, return-stack entries (power of 2, 2..16).

Ports:
CLK  input  1  system clock, rising edge.
reset_ctrl_n  input  1  asynchronous active-low reset.
pc_in  input  16  current PC from the PC register.
start  input  1  begin/restart execution (1-cycle pulse).
stall  input  1  hold the PC.
halt  input  1  end of program.
branch_taken  input  1  conditional branch resolved taken.
branch_off  input  8  signed PC-relative offset.
jump  input  1  absolute jump.
jump_target  input  16  absolute target.
call  input  1  jump to jump_target and push return address.
ret  input  1  pop return address.
pcnext_out  output  16  next-PC value to the PC register.
done  output  1  processor halted.
rs_count  output  $clog2(RS_DEPTH)+1  return-stack occupancy.
rs_overflow  output  1  sticky: call attempted while stack full.
rs_underflow  output  1  sticky: ret attempted while stack empty.

Behaviour:
- Reset (async, reset_ctrl_n=0):
  - State goes to IDLE.
  - done=0, rs_count=0, both error flags cleared.
  - pcnext_out=START_ADDR immediately.
- States and transitions:
  - IDLE: pcnext_out=START_ADDR. All controls except start are ignored. start moves to RUN next edge.
  - RUN: pcnext_out is selected by fixed priority: stall > halt > ret > call > jump > branch_taken > sequential. Only the highest asserted request takes effect.
    - stall: pcnext_out=pc_in. No stack change.
    - halt: pcnext_out=pc_in. State goes to DONE next edge.
    - ret, stack non-empty: pcnext_out=top entry. Pop at edge.
    - ret, stack empty: pcnext_out=pc_in+1. rs_underflow set at edge.
    - call: pcnext_out=jump_target. Push pc_in+1 at edge. If full, do not push, set rs_overflow, but still jump.
    - jump: pcnext_out=jump_target.
    - branch_taken: pcnext_out=pc_in + sign_extend(branch_off).
    - Otherwise: pcnext_out=pc_in+1.
  - DONE: pcnext_out=pc_in (hold), done=1. Other controls are ignored. start returns to RUN and does the restart actions below.
- start while in RUN or DONE is a restart:
  - pcnext_out=START_ADDR that cycle.
  - Stack emptied, error flags cleared, done cleared at edge.
  - State is RUN after the edge.
  - start overrides all other controls in every state.
- Arithmetic: all PC math is modulo 2^16 with silent wrap. 16'hFFFF+1 = 16'h0000. 16'h0002 + (-4) = 16'hFFFE.
- Stack:
  - LIFO with storage indexed by rs_count.
  - rs_count is registered and never exceeds RS_DEPTH or goes below 0.
  - Error flags are sticky until reset or start.
- Simultaneous call and ret: ret wins. No push occurs.
- A stalled call or ret has no stack effect; it is re-presented by the decoder.
- done is registered: asserts the edge after halt is accepted.
- Reset mid-operation discards all stack contents and state.

Decomposition:
- Shared package pc_pkg holds:
  - state enum pcu_state_t {IDLE, RUN, DONE};
  - PC_W=16;
  - the next-PC select enum (SEL_START, SEL_HOLD, SEL_RAS, SEL_TARGET, SEL_BRANCH, SEL_SEQ).
- One sub-module, return_stack: parameterized LIFO with push, pop, clear, top, count, full, empty. Same clock and reset.
- FSM and next-PC mux stay in pc_next_unit.

Test Plan:
- Reset then start, no controls for 3 cycles, pc_in fed back from PC register -> pcnext_out sequence 0x0000, 0x0001, 0x0002, 0x0003.
- pc_in=0x0010, branch_taken with off=8'hF8 -> pcnext_out=0x0008. pc_in=0xFFFF sequential -> 0x0000.
- pc_in=0x0020, call with target 0x0100 -> pcnext_out=0x0100, rs_count=1. Later, pc_in=0x0105 with ret -> pcnext_out=0x0021, rs_count=0.
- Five nested calls with RS_DEPTH=4 -> rs_overflow=1, rs_count=4, fifth target still taken. Then five rets -> last ret gives pc_in+1 and rs_underflow=1.
- stall together with jump -> pcnext_out=pc_in for every stalled cycle. Deassert stall -> jump_target taken.
- halt at pc_in=0x0042 -> done=1 next cycle, pcnext_out holds 0x0042. Then start -> pcnext_out=0x0000, flags clear. Async reset asserted mid-RUN -> outputs return to reset values without a clock edge.
